// File: rtl/usb_slave_fifo_writer.sv
// usb_slave_fifo_writer
// Drains the merged 16-bit sample stream into an FX2-style synchronous slave FIFO
// (IN endpoint, AUTOIN). A small skid buffer absorbs the full-flag latency. Short
// packets are committed with PKTEND on a flush request or after an idle timeout.
//
// Ports:
//   clk, reset_n     system/IFCLK clock, asynchronous active-low reset
//   din, din_en      upstream word and its valid (one word per cycle)
//   buf_afull        upstream throttle, buffer count >= depth-4
//   flush_req        pulse: commit the current partial packet
//   usb_full_n       slave FIFO full flag (0 = full)
//   usb_fd           slave FIFO data bus (registered)
//   usb_slwr_n       write strobe, active-low (registered)
//   usb_pktend_n     packet-end strobe, active-low (registered)
//   usb_fifoadr      endpoint select, constant EP_ADDR (registered)
//   overflow_err     sticky: a din_en word was dropped
//   words_written    count of strobed words since reset, wraps
module usb_slave_fifo_writer #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned BUF_AW      = 4,
   parameter int unsigned PKT_WORDS   = 256,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter logic [1:0]  EP_ADDR     = 2'b10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_en,
   output logic                  buf_afull,
   input  logic                  flush_req,
   input  logic                  usb_full_n,
   output logic [DATA_WIDTH-1:0] usb_fd,
   output logic                  usb_slwr_n,
   output logic                  usb_pktend_n,
   output logic [1:0]            usb_fifoadr,
   output logic                  overflow_err,
   output logic [31:0]           words_written
);

   localparam int unsigned BufDepth = 2 ** BUF_AW;
   localparam int unsigned PktAw    = $clog2(PKT_WORDS);
   localparam int unsigned IdleW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [BUF_AW:0]  CntFull  = (BUF_AW + 1)'(BufDepth);
   localparam logic [BUF_AW:0]  CntAfull = (BUF_AW + 1)'(BufDepth - 4);
   localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {StIdle, StWrite, StGap, StPktend} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem_q [BufDepth];
   logic [BUF_AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [BUF_AW:0]       count_q, count_d;
   logic [PktAw-1:0]      pkt_cnt_q, pkt_cnt_d;
   logic [IdleW-1:0]      idle_cnt_q, idle_cnt_d;
   logic                  flush_pend_q, flush_pend_d;
   logic                  gap_q, gap_d;
   logic [DATA_WIDTH-1:0] usb_fd_q, usb_fd_d;
   logic                  slwr_n_q, slwr_n_d;
   logic                  pktend_n_q, pktend_n_d;
   logic [1:0]            fifoadr_q;
   logic                  overflow_q, overflow_d;
   logic [31:0]           words_q, words_d;

   logic buf_empty, buf_full, can_pop, pop, push, flush_clr, idle_timeout;

   assign buf_empty    = (count_q == '0);
   assign buf_full     = (count_q == CntFull);
   assign can_pop      = !buf_empty && usb_full_n;
   assign idle_timeout = (idle_cnt_q == IdleMax);
   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign push         = din_en && (!buf_full || pop);

   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      pop        = 1'b0;
      flush_clr  = 1'b0;
      slwr_n_d   = 1'b1;
      pktend_n_d = 1'b1;
      usb_fd_d   = usb_fd_q;
      pkt_cnt_d  = pkt_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (can_pop) begin
               pop     = 1'b1;
               state_d = StWrite;
            end else if (buf_empty && (pkt_cnt_q != '0) && (flush_pend_q || idle_timeout)) begin
               pktend_n_d = 1'b0;
               state_d    = StPktend;
            end else if (buf_empty && flush_pend_q && (pkt_cnt_q == '0)) begin
               // Nothing to commit: drop the request rather than send a zero-length packet.
               flush_clr = 1'b1;
            end
         end
         StWrite: begin
            // pkt_cnt_q counts the word now on the bus; zero means it closed a packet.
            if (pkt_cnt_q == '0) begin
               gap_d   = 1'b0;
               state_d = StGap;
            end else if (can_pop) begin
               pop = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         StGap: begin
            if (gap_q) begin
               state_d = StIdle;
            end else begin
               gap_d = 1'b1;
            end
         end
         StPktend: begin
            pkt_cnt_d = '0;
            gap_d     = 1'b0;
            state_d   = StGap;
         end
         default: state_d = StIdle;
      endcase

      if (pop) begin
         usb_fd_d  = mem_q[rd_ptr_q];
         slwr_n_d  = 1'b0;
         pkt_cnt_d = pkt_cnt_q + PktAw'(1);
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + BUF_AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + BUF_AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + (BUF_AW + 1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (BUF_AW + 1)'(1);
      end

      if (flush_pend_q) begin
         flush_pend_d = !(flush_clr || (state_q == StPktend));
      end else begin
         flush_pend_d = flush_req;
      end

      idle_cnt_d = idle_cnt_q;
      if (push || pop || (state_q == StPktend)) begin
         idle_cnt_d = '0;
      end else if (buf_empty && (pkt_cnt_q != '0) && !idle_timeout) begin
         idle_cnt_d = idle_cnt_q + IdleW'(1);
      end

      overflow_d = overflow_q || (din_en && buf_full && !pop);
      words_d    = slwr_n_q ? words_q : words_q + 32'd1;
   end

   // Buffer storage needs no reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         pkt_cnt_q    <= '0;
         idle_cnt_q   <= '0;
         flush_pend_q <= 1'b0;
         gap_q        <= 1'b0;
         usb_fd_q     <= '0;
         slwr_n_q     <= 1'b1;
         pktend_n_q   <= 1'b1;
         fifoadr_q    <= EP_ADDR;
         overflow_q   <= 1'b0;
         words_q      <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         pkt_cnt_q    <= pkt_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
         flush_pend_q <= flush_pend_d;
         gap_q        <= gap_d;
         usb_fd_q     <= usb_fd_d;
         slwr_n_q     <= slwr_n_d;
         pktend_n_q   <= pktend_n_d;
         fifoadr_q    <= EP_ADDR;
         overflow_q   <= overflow_d;
         words_q      <= words_d;
      end
   end

   assign buf_afull     = (count_q >= CntAfull);
   assign usb_fd        = usb_fd_q;
   assign usb_slwr_n    = slwr_n_q;
   assign usb_pktend_n  = pktend_n_q;
   assign usb_fifoadr   = fifoadr_q;
   assign overflow_err  = overflow_q;
   assign words_written = words_q;

endmodule
